// File: rtl/d16_bus_pkg.sv
// d16_bus_pkg -- shared constants and types for the d16 memory bus.
//   Arbiter state encoding doubles as the one-hot grant vector:
//   bit 0 = M0 owns the bus, bit 1 = M1 owns the bus, 00 = idle.
//   Width and timeout defaults are shared with the d16 core and decoder.
package d16_bus_pkg;

   localparam int D16_AW      = 16;
   localparam int D16_DW      = 16;
   localparam int D16_TIMEOUT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } arb_state_e;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_e;

endpackage

// File: rtl/d16_rr_pick2.sv
// d16_rr_pick2 -- combinational two-way round-robin pick.
//   i_req0, i_req1 : request lines of M0 / M1
//   i_last_owner   : master that owned the bus most recently
//   o_valid        : at least one request present
//   o_pick         : winner; on a tie the master that did not own last
module d16_rr_pick2
   import d16_bus_pkg::*;
(
   input  logic    i_req0,
   input  logic    i_req1,
   input  master_e i_last_owner,
   output logic    o_valid,
   output master_e o_pick
);

   always_comb begin
      o_valid = i_req0 | i_req1;
      o_pick  = M0;
      if (i_req0 && i_req1) begin
         o_pick = (i_last_owner == M0) ? M1 : M0;
      end else if (i_req1) begin
         o_pick = M1;
      end
   end

endmodule

// File: rtl/d16_bus_arbiter.sv
// d16_bus_arbiter -- shares the d16 memory bus between the CPU (M0) and a
// second master (M1). Adds per-master stall, per-transaction ack and a
// watchdog that force-terminates transactions the slave never acks.
//
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_mX_cyc/we/addr/dat              master X request, write enable, address, write data
//   o_mX_dat/ack/err/stall            master X read data, done, timed out, waiting for grant
//   o_s_cyc/we/addr/dat               slave request side (muxed from the owner)
//   i_s_dat, i_s_ack                  slave read data and done
//   o_grant                           one-hot current owner, 00 when idle
//
// Every transaction spends one IDLE cycle arbitrating before the owned
// cycles; all bus-side outputs are combinational from the registered state.
module d16_bus_arbiter
   import d16_bus_pkg::*;
#(
   parameter int AW      = D16_AW,
   parameter int DW      = D16_DW,
   parameter int TIMEOUT = D16_TIMEOUT
) (
   input  logic          i_clk,
   input  logic          i_reset,

   input  logic          i_m0_cyc,
   input  logic          i_m0_we,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_dat,
   output logic [DW-1:0] o_m0_dat,
   output logic          o_m0_ack,
   output logic          o_m0_err,
   output logic          o_m0_stall,

   input  logic          i_m1_cyc,
   input  logic          i_m1_we,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_dat,
   output logic [DW-1:0] o_m1_dat,
   output logic          o_m1_ack,
   output logic          o_m1_err,
   output logic          o_m1_stall,

   output logic          o_s_cyc,
   output logic          o_s_we,
   output logic [AW-1:0] o_s_addr,
   output logic [DW-1:0] o_s_dat,
   input  logic [DW-1:0] i_s_dat,
   input  logic          i_s_ack,

   output logic [1:0]    o_grant
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   arb_state_e state_q, state_d;
   master_e    last_owner_q, last_owner_d;
   logic [7:0] timer_q, timer_d;

   logic    own0, own1, owned;
   logic    timeout, done;
   logic    pick_valid;
   master_e pick;

   d16_rr_pick2 u_pick (
      .i_req0       (i_m0_cyc),
      .i_req1       (i_m1_cyc),
      .i_last_owner (last_owner_q),
      .o_valid      (pick_valid),
      .o_pick       (pick)
   );

   assign own0  = (state_q == ST_OWN0);
   assign own1  = (state_q == ST_OWN1);
   assign owned = own0 | own1;

   // A late slave ack on the watchdog cycle wins: normal ack, no err.
   assign timeout = owned & (timer_q == TMO_LAST) & ~i_s_ack;
   assign done    = owned & (i_s_ack | timeout);

   // Bus-side outputs
   always_comb begin
      o_s_cyc  = 1'b0;
      o_s_we   = 1'b0;
      o_s_addr = '0;
      o_s_dat  = '0;
      if (own0) begin
         o_s_cyc  = i_m0_cyc;
         o_s_we   = i_m0_we;
         o_s_addr = i_m0_addr;
         o_s_dat  = i_m0_dat;
      end else if (own1) begin
         o_s_cyc  = i_m1_cyc;
         o_s_we   = i_m1_we;
         o_s_addr = i_m1_addr;
         o_s_dat  = i_m1_dat;
      end
   end

   assign o_grant    = state_q;  // state encoding is the one-hot grant

   assign o_m0_dat   = own0 ? i_s_dat : '0;
   assign o_m1_dat   = own1 ? i_s_dat : '0;
   assign o_m0_ack   = own0 & done;
   assign o_m1_ack   = own1 & done;
   assign o_m0_err   = own0 & timeout;
   assign o_m1_err   = own1 & timeout;
   assign o_m0_stall = i_m0_cyc & ~own0;
   assign o_m1_stall = i_m1_cyc & ~own1;

   // Next state, owner history and watchdog timer
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      timer_d      = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d      = (pick == M0) ? ST_OWN0 : ST_OWN1;
               last_owner_d = pick;
            end
         end
         ST_OWN0: begin
            // Abort (cyc dropped) and completion both return to IDLE.
            if (done || !i_m0_cyc) state_d = ST_IDLE;
            else                   timer_d = timer_q + 8'd1;
         end
         ST_OWN1: begin
            if (done || !i_m1_cyc) state_d = ST_IDLE;
            else                   timer_d = timer_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         last_owner_q <= M1;  // M0 wins the first tie after reset
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         timer_q      <= timer_d;
      end
   end

endmodule

// File: tb/tb_d16_bus_arbiter.sv
// Bench for d16_bus_arbiter: constant vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level model.
module tb_d16_bus_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 15;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_m0_cyc, i_m0_we, i_m1_cyc, i_m1_we, i_s_ack;
   logic [AW-1:0] i_m0_addr, i_m1_addr;
   logic [DW-1:0] i_m0_dat, i_m1_dat, i_s_dat;
   logic [DW-1:0] o_m0_dat, o_m1_dat, o_s_dat;
   logic [AW-1:0] o_s_addr;
   logic          o_m0_ack, o_m0_err, o_m0_stall;
   logic          o_m1_ack, o_m1_err, o_m1_stall;
   logic          o_s_cyc, o_s_we;
   logic [1:0]    o_grant;

   d16_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_cyc(i_m0_cyc), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_stall(o_m0_stall),
      .i_m1_cyc(i_m1_cyc), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_stall(o_m1_stall),
      .o_s_cyc(o_s_cyc), .o_s_we(o_s_we), .o_s_addr(o_s_addr), .o_s_dat(o_s_dat),
      .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .o_grant(o_grant)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   // Model: who owns the bus (-1 none), who owned last, owned cycles so far.
   int   m_owner, m_last, m_cnt;
   logic e_ack0, e_ack1;

   typedef struct {
      logic       c0, c1, sack;
      logic [8:0] exp;  // {grant[1:0], s_cyc, stall0, stall1, ack0, ack1, err0, err1}
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic c0, c1, o0, o1, tmo, ack;
      logic [AW+DW+1:0] es;
      logic [DW+2:0]    e0, e1;
      c0  = i_m0_cyc;
      c1  = i_m1_cyc;
      o0  = (m_owner == 0);
      o1  = (m_owner == 1);
      tmo = (o0 | o1) && (m_cnt == TO - 1) && !i_s_ack;
      ack = (o0 | o1) && (i_s_ack || tmo);
      if (o0)      es = {c0, i_m0_we, i_m0_addr, i_m0_dat};
      else if (o1) es = {c1, i_m1_we, i_m1_addr, i_m1_dat};
      else         es = '0;
      e0 = {o0 ? i_s_dat : 16'h0, o0 & ack, o0 & tmo, c0 & !o0};
      e1 = {o1 ? i_s_dat : 16'h0, o1 & ack, o1 & tmo, c1 & !o1};
      e_ack0 = o0 & ack;
      e_ack1 = o1 & ack;
      chk("grant", 64'(o_grant), 64'({o1, o0}));
      chk("slave_side", 64'({o_s_cyc, o_s_we, o_s_addr, o_s_dat}), 64'(es));
      chk("m0_side", 64'({o_m0_dat, o_m0_ack, o_m0_err, o_m0_stall}), 64'(e0));
      chk("m1_side", 64'({o_m1_dat, o_m1_ack, o_m1_err, o_m1_stall}), 64'(e1));
      chk("one_ack", 64'(o_m0_ack & o_m1_ack), 64'(0));
   endtask

   task automatic model_step();
      logic c[2];
      logic ack;
      c[0] = i_m0_cyc;
      c[1] = i_m1_cyc;
      if (i_reset) begin
         m_owner = -1; m_last = 1; m_cnt = 0;
      end else if (m_owner < 0) begin
         if (c[0] && c[1]) m_owner = 1 - m_last;
         else if (c[0])    m_owner = 0;
         else if (c[1])    m_owner = 1;
         if (m_owner >= 0) begin
            m_last = m_owner;
            m_cnt  = 0;
         end
      end else begin
         ack = i_s_ack || (m_cnt == TO - 1);
         if (ack || !c[m_owner]) begin
            m_owner = -1;
            m_cnt   = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   // One clock: compare mid-cycle, advance model on the edge, return at edge+1.
   task automatic tick();
      @(negedge i_clk);
      model_check();
      @(posedge i_clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      i_m0_cyc = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_dat = '0;
      i_m1_cyc = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_dat = '0;
      i_s_ack = 0; i_s_dat = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_reset = 1;
      @(posedge i_clk);
      model_step();
      #1;
      i_reset = 0;
   endtask

   initial begin
      vecs[0] = '{1, 1, 0, 9'b00_0_11_00_00};
      vecs[1] = '{1, 1, 1, 9'b01_1_01_10_00};
      vecs[2] = '{1, 1, 0, 9'b00_0_11_00_00};
      vecs[3] = '{1, 1, 1, 9'b10_1_10_01_00};
      vecs[4] = '{1, 1, 0, 9'b00_0_11_00_00};
      vecs[5] = '{1, 1, 0, 9'b01_1_01_00_00};
      vecs[6] = '{0, 1, 1, 9'b01_0_01_10_00};  // abort + ack: ack still reported
      vecs[7] = '{0, 1, 1, 9'b00_0_01_00_00};  // ack in IDLE ignored
      vecs[8] = '{0, 1, 0, 9'b10_1_00_00_00};

      i_reset = 1;
      idle_inputs();
      @(posedge i_clk); #1;
      do_reset();

      // Reset state: all outputs zero with idle inputs
      #3;
      chk("reset_outputs", 64'({o_grant, o_s_cyc, o_s_we, o_s_addr, o_s_dat, o_m0_ack, o_m1_ack,
                                o_m0_err, o_m1_err, o_m0_stall, o_m1_stall}), 64'(0));
      chk("reset_rdata", 64'({o_m0_dat, o_m1_dat}), 64'(0));
      tick();

      // Vector table: tie after reset, alternation, abort+ack, ack in IDLE
      for (int i = 0; i < 9; i++) begin
         i_m0_cyc = vecs[i].c0;
         i_m1_cyc = vecs[i].c1;
         i_s_ack  = vecs[i].sack;
         #3;
         chk($sformatf("vec%0d", i), 64'({o_grant, o_s_cyc, o_m0_stall, o_m1_stall,
                                          o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}), 64'(vecs[i].exp));
         tick();
      end

      // Single M0 read, ack in second owned cycle
      do_reset();
      i_m0_cyc = 1; i_m0_addr = 16'h0010;
      #3; chk("rd_stall", 64'(o_m0_stall), 64'(1));
      tick();
      #3; chk("rd_addr", 64'({o_grant, o_s_cyc, o_s_addr}), 64'({2'b01, 1'b1, 16'h0010}));
      tick();
      i_s_ack = 1; i_s_dat = 16'hBEEF;
      #3; chk("rd_ack", 64'({o_m0_ack, o_m0_err, o_m0_dat}), 64'({2'b10, 16'hBEEF}));
      tick();
      i_s_ack = 0; i_s_dat = '0; i_m0_cyc = 0;
      #3; chk("rd_idle", 64'(o_grant), 64'(0));
      tick();

      // M1 write while M0 idle
      do_reset();
      i_m1_cyc = 1; i_m1_we = 1; i_m1_addr = 16'h8000; i_m1_dat = 16'h1234;
      tick();
      i_s_ack = 1; i_s_dat = 16'h5555;
      #3;
      chk("wr_bus", 64'({o_s_we, o_s_addr, o_s_dat}), 64'({1'b1, 16'h8000, 16'h1234}));
      chk("wr_ack", 64'({o_m1_ack, o_m1_err, o_grant}), 64'({2'b10, 2'b10}));
      chk("wr_m0_quiet", 64'({o_m0_dat, o_m0_ack, o_m0_err, o_m0_stall}), 64'(0));
      tick();
      idle_inputs();
      tick();

      // Watchdog: slave never acks; M1 waits behind M0
      do_reset();
      i_m0_cyc = 1; i_m1_cyc = 1;
      tick();
      for (int n = 1; n <= TO; n++) begin
         #3;
         chk($sformatf("tmo_cyc%0d", n), 64'({o_m0_ack, o_m0_err, o_m1_stall}),
             64'((n == TO) ? 3'b111 : 3'b001));
         tick();
      end
      i_m0_cyc = 0;
      #3; chk("tmo_s_cyc_low", 64'({o_s_cyc, o_grant}), 64'(0));
      tick();
      #3; chk("tmo_m1_granted", 64'(o_grant), 64'(2'b10));
      tick();
      idle_inputs();
      tick();

      // Ack on the watchdog cycle: normal ack
      do_reset();
      i_m0_cyc = 1;
      tick();
      for (int n = 1; n < TO; n++) tick();
      i_s_ack = 1;
      #3; chk("late_ack", 64'({o_m0_ack, o_m0_err}), 64'(2'b10));
      tick();
      idle_inputs();
      tick();

      // M1 abort after 3 owned cycles, M0 pending
      do_reset();
      i_m1_cyc = 1;
      tick();
      i_m0_cyc = 1;
      for (int n = 0; n < 3; n++) tick();
      i_m1_cyc = 0;
      #3; chk("abort_no_ack", 64'({o_m1_ack, o_m1_err, o_s_cyc}), 64'(0));
      tick();
      #3; chk("abort_idle", 64'({o_grant, o_m0_stall}), 64'({2'b00, 1'b1}));
      tick();
      #3; chk("abort_m0_granted", 64'(o_grant), 64'(2'b01));
      tick();
      idle_inputs();
      tick();

      // Reset while M0 owns and the slave stalls
      do_reset();
      i_m0_cyc = 1;
      tick();
      tick();
      i_reset = 1;
      tick();
      i_reset = 0;
      #3; chk("rst_mid", 64'({o_s_cyc, o_grant, o_m0_ack, o_m0_err}), 64'(0));
      i_m1_cyc = 1;
      tick();
      #3; chk("rst_tie_m0", 64'(o_grant), 64'(2'b01));
      tick();
      idle_inputs();
      tick();

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (!i_m0_cyc) i_m0_cyc = ($urandom % 3 == 0);
         else if (e_ack0 ? ($urandom % 2 == 0) : ($urandom % 40 == 0)) i_m0_cyc = 0;
         if (!i_m1_cyc) i_m1_cyc = ($urandom % 3 == 0);
         else if (e_ack1 ? ($urandom % 2 == 0) : ($urandom % 40 == 0)) i_m1_cyc = 0;
         i_m0_we   = 1'($urandom);
         i_m1_we   = 1'($urandom);
         i_m0_addr = 16'($urandom);
         i_m1_addr = 16'($urandom);
         i_m0_dat  = 16'($urandom);
         i_m1_dat  = 16'($urandom);
         i_s_dat   = 16'($urandom);
         i_s_ack   = (n < 1500) ? ($urandom % 4 == 0) : ($urandom % 24 == 0);
         i_reset   = ($urandom % 400 == 0);
         tick();
      end
      i_reset = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
